// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, control words
// and the classification of which operations update the carry flag.
package alu_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_OR  = 4'd2,
        OP_NOT = 4'd3,
        OP_XOR = 4'd4,
        OP_AND = 4'd5,
        OP_MOV = 4'd6,
        OP_INC = 4'd7,
        OP_DEC = 4'd8,
        OP_SLA = 4'd9,
        OP_SLL = 4'd10,
        OP_ROL = 4'd11,
        OP_SRA = 4'd12,
        OP_SRL = 4'd13,
        OP_ROR = 4'd14,
        OP_ILL = 4'd15
    } op_e;

    localparam logic [5:0] CTRL_ADD  = 6'b010010;
    localparam logic [5:0] CTRL_SUB  = 6'b100010;
    localparam logic [5:0] CTRL_OR   = 6'b010100;
    localparam logic [5:0] CTRL_NOT  = 6'b001100;
    localparam logic [5:0] CTRL_XOR  = 6'b011100;
    localparam logic [5:0] CTRL_AND  = 6'b011000;
    localparam logic [5:0] CTRL_MOV  = 6'b000000;
    localparam logic [5:0] CTRL_INC  = 6'b110110;
    localparam logic [5:0] CTRL_DEC  = 6'b000110;
    localparam logic [5:0] CTRL_SLA  = 6'b001001;
    localparam logic [5:0] CTRL_SLL  = 6'b000001;
    localparam logic [5:0] CTRL_ROL  = 6'b010001;
    localparam logic [5:0] CTRL_SRA  = 6'b001101;
    localparam logic [5:0] CTRL_SRL  = 6'b000101;
    localparam logic [5:0] CTRL_ROR  = 6'b010101;
    localparam logic [5:0] CTRL_IDLE = 6'b000000;

    typedef struct packed {
        logic [5:0] ctrl;
        logic       carry_upd;
        logic       is_shift;
        logic       illegal;
    } enc_t;

    function automatic logic is_shift_op(input op_e op);
        return (op >= OP_SLA) && (op <= OP_ROR);
    endfunction

    // Arithmetic and shift/rotate ops produce a carry worth keeping; logic ops do not.
    function automatic logic updates_carry(input op_e op);
        case (op)
            OP_ADD, OP_SUB, OP_INC, OP_DEC: return 1'b1;
            default:                        return is_shift_op(op);
        endcase
    endfunction

endpackage

// File: rtl/alu_op_enc.sv
// Combinational opcode decoder: control word, carry-update flag, shift class
// and illegal-opcode detection.
module alu_op_enc
    import alu_ctrl_pkg::*;
(
    input  logic [3:0] op_code,
    output enc_t       enc
);

    op_e op;

    assign op = op_e'(op_code);

    always_comb begin
        // NOTE: default every field first so no path through the case infers a latch.
        enc           = '0;
        enc.carry_upd = updates_carry(op);
        enc.is_shift  = is_shift_op(op);
        enc.illegal   = (op == OP_ILL);
        case (op)
            OP_ADD:  enc.ctrl = CTRL_ADD;
            OP_SUB:  enc.ctrl = CTRL_SUB;
            OP_OR:   enc.ctrl = CTRL_OR;
            OP_NOT:  enc.ctrl = CTRL_NOT;
            OP_XOR:  enc.ctrl = CTRL_XOR;
            OP_AND:  enc.ctrl = CTRL_AND;
            OP_MOV:  enc.ctrl = CTRL_MOV;
            OP_INC:  enc.ctrl = CTRL_INC;
            OP_DEC:  enc.ctrl = CTRL_DEC;
            OP_SLA:  enc.ctrl = CTRL_SLA;
            OP_SLL:  enc.ctrl = CTRL_SLL;
            OP_ROL:  enc.ctrl = CTRL_ROL;
            OP_SRA:  enc.ctrl = CTRL_SRA;
            OP_SRL:  enc.ctrl = CTRL_SRL;
            OP_ROR:  enc.ctrl = CTRL_ROR;
            default: enc.ctrl = CTRL_IDLE;
        endcase
    end

endmodule

// File: rtl/alu_op_seq.sv
// ALU operation sequencer: accepts opcodes over a valid/ready handshake and
// drives registered ALU control words. ALU_OP_SEQ_MULTISHIFT_EN enables
// repeated shift/rotate cycles driven by op_count.
module alu_op_seq
    import alu_ctrl_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op_code,
    input  logic [CNT_W-1:0] op_count,
    input  logic             alu_carry,
    output logic [5:0]       ctrl,
    output logic             ctrl_valid,
    output logic             c_flag,
    output logic             done,
    output logic             op_err
);

`ifdef ALU_OP_SEQ_MULTISHIFT_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1
    } state_e;
`endif

    state_e state;
    enc_t   enc;
    logic   carry_upd_q;
    logic   transfer;

    alu_op_enc u_enc (
        .op_code (op_code),
        .enc     (enc)
    );

    // done marks the last execute cycle, which is exactly when a new opcode may enter.
    assign op_ready = (state == IDLE) || done;
    assign transfer = op_valid && op_ready;

`ifdef ALU_OP_SEQ_MULTISHIFT_EN
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_load;
    logic [CNT_W-1:0] cnt_next;

    assign cnt_load = (!enc.is_shift || op_count == '0) ? CNT_W'(1) : op_count;
    assign cnt_next = (cnt > CNT_W'(1)) ? cnt - CNT_W'(1) : cnt;
`else
    logic unused_inputs;
    assign unused_inputs = ^{op_count, enc.is_shift};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ctrl        <= CTRL_IDLE;
            ctrl_valid  <= 1'b0;
            c_flag      <= 1'b0;
            done        <= 1'b0;
            op_err      <= 1'b0;
            carry_upd_q <= 1'b0;
`ifdef ALU_OP_SEQ_MULTISHIFT_EN
            cnt         <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            if (ctrl_valid && carry_upd_q)
                c_flag <= alu_carry;

            if (op_ready) begin
                if (transfer) begin
                    state       <= EXEC;
                    ctrl        <= enc.ctrl;
                    ctrl_valid  <= 1'b1;
                    op_err      <= enc.illegal;
                    carry_upd_q <= enc.carry_upd;
`ifdef ALU_OP_SEQ_MULTISHIFT_EN
                    cnt         <= cnt_load;
                    done        <= (cnt_load == CNT_W'(1));
`else
                    done        <= 1'b1;
`endif
                end else begin
                    state       <= IDLE;
                    ctrl        <= CTRL_IDLE;
                    ctrl_valid  <= 1'b0;
                    done        <= 1'b0;
                    op_err      <= 1'b0;
                    carry_upd_q <= 1'b0;
                end
            end
`ifdef ALU_OP_SEQ_MULTISHIFT_EN
            else begin
                // Repeat the held shift word; the next cycle is last once one repetition remains.
                state <= SHIFT;
                cnt   <= cnt_next;
                done  <= (cnt_next == CNT_W'(1));
            end
`endif
        end
    end

endmodule

// File: doc/alu_op_seq.md
ALU_OP_SEQ -- requirements
Module: alu_op_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 4, width of shift-count input and internal repeat counter.
REQ-002 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 op_valid  in  1  upstream offers an opcode this cycle.
REQ-005 op_ready  out  1  block accepts the opcode this cycle.
REQ-006 op_code  in  4  operation select, 0..14 = ADD,SUB,OR,NOT,XOR,AND,MOV,INC,DEC,SLA,SLL,ROL,SRA,SRL,ROR; 15 illegal.
REQ-007 op_count  in  CNT_W  shift/rotate repeat count.
REQ-008 alu_carry  in  1  carry-out returned by the ALU for the current control word.
REQ-009 ctrl  out  6  ALU control word; bit i is control line Ctrl<i>.
REQ-010 ctrl_valid  out  1  ctrl is an active operation this cycle.
REQ-011 c_flag  out  1  registered carry flag fed to the ALU control decoders.
REQ-012 done  out  1  one-cycle pulse on the last execute cycle of an operation.
REQ-013 op_err  out  1  one-cycle pulse, coincident with done, for illegal opcode.

Function
REQ-014 Handshake: transfer occurs on a rising edge where op_valid && op_ready; op_code/op_count are sampled only then.
REQ-015 FSM states IDLE, EXEC, SHIFT; IDLE->EXEC on transfer; EXEC->SHIFT if shift/rotate and remaining count >1 (macro on); EXEC/SHIFT->EXEC on last cycle with new transfer; ->IDLE on last cycle without transfer.
REQ-016 op_ready SHALL be 1 in IDLE and in the last execute cycle (back-to-back, no bubble); 0 otherwise.
REQ-017 Latency: opcode accepted at edge N drives ctrl/ctrl_valid from edge N through edge N+1 (registered outputs, one cycle after transfer).
REQ-018 ctrl encoding (ctrl[5:0]): ADD 010010, SUB 100010, OR 010100, NOT 001100, XOR 011100, AND 011000, MOV 000000, INC 110110, DEC 000110, SLA 001001, SLL 000001, ROL 010001, SRA 001101, SRL 000101, ROR 010101.
REQ-019 Illegal opcode 15: one EXEC cycle with ctrl=000000, ctrl_valid=1, done=1, op_err=1, c_flag unchanged.
REQ-020 When ctrl_valid=0, ctrl SHALL be 000000.
REQ-021 c_flag SHALL load alu_carry at the end of every execute cycle of ADD, SUB, INC, DEC and all shift/rotate ops; OR, NOT, XOR, AND, MOV, illegal SHALL hold it.
REQ-022 Shift count: op_count=0 treated as 1; repeat counter decrements per cycle, never wraps below 1.
REQ-023 done asserts exactly once per accepted opcode, in the cycle ctrl for its final repetition is valid.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, ctrl=000000, ctrl_valid=0, c_flag=0, done=0, op_err=0, counter=0; op_ready=1 after release.
REQ-025 Reset during EXEC/SHIFT SHALL abandon the operation with no done pulse.

Configuration
REQ-026 Macro ALU_OP_SEQ_MULTISHIFT_EN defined: shift/rotate ops repeat the same ctrl word for op_count cycles via SHIFT state.
REQ-027 Macro undefined: op_count ignored, all ops single EXEC cycle, SHIFT state and counter absent.

Structure
REQ-028 Shared package alu_ctrl_pkg SHALL hold the opcode enum, the 15 ctrl-word constants, and the carry-update classification.
REQ-029 Sub-module alu_op_enc (combinational opcode -> ctrl word + carry-update + shift class) SHALL be instantiated once.

Verification
REQ-030 Reset then ADD (code 0), alu_carry=1 -> next cycle ctrl=010010, ctrl_valid=1, done=1; c_flag=1 after that edge.
REQ-031 Back-to-back SUB,XOR,MOV with op_valid held -> ctrl 100010,011100,000000 on consecutive cycles, op_ready never 0, c_flag changed only by SUB.
REQ-032 Macro on, SLL with op_count=3 -> ctrl=000001 for 3 cycles, op_ready=0 for first 2, done only on 3rd; op_count=0 -> 1 cycle.
REQ-033 Opcode 15 -> one cycle ctrl=000000, done=1, op_err=1, c_flag held.
REQ-034 rst_n asserted mid ROR (count 5) -> outputs at reset values asynchronously, no done, op_ready=1 after release.
REQ-035 Macro off, ROL with op_count=7 -> single cycle ctrl=010001, done=1.
